// File: rtl/tft_pkg.sv
// Shared definitions for the 480x272 TFT colour-bar path:
// sequencer state encoding, PWM ceiling, panel timing constants and
// small arithmetic helpers used by tft_pattern_ctrl.
package tft_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_FADE = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [7:0] PWM_MAX = 8'd255;

  // Panel timing totals shared with tft_ctrl (pixels per line, lines per frame).
  localparam int H_TOTAL = 525;
  localparam int V_TOTAL = 286;

  // Next pattern index, wrapping to 0 after the last pattern.
  function automatic logic [2:0] next_pat(input logic [2:0] cur, input logic [2:0] last);
    logic [2:0] nxt;
    if (cur == last) begin
      nxt = 3'd0;
    end else begin
      nxt = cur + 3'd1;
    end
    return nxt;
  endfunction

  // Duty increment saturating at PWM_MAX, using a 9-bit sum.
  function automatic logic [7:0] sat_add(input logic [7:0] duty, input logic [7:0] step);
    logic [8:0] sum;
    logic [7:0] res;
    sum = {1'b0, duty} + {1'b0, step};
    if (sum > {1'b0, PWM_MAX}) begin
      res = PWM_MAX;
    end else begin
      res = sum[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bl_pwm.sv
// Backlight PWM: free-running 8-bit counter (period 256 clocks) and a
// registered comparator output. duty 0 gives constant off, duty 255
// gives constant on.
module bl_pwm
  import tft_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty,
  output logic       tft_bl
);

  logic [7:0] pwm_cnt;

  // Counter wraps 255->0; output compares the current count with duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
      tft_bl  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      tft_bl  <= (duty == PWM_MAX) | (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/tft_pattern_ctrl.sv
// Frame-synchronous test-pattern sequencer and backlight owner.
// After reset the backlight stays off for START_FRAMES frames, then fades
// in by FADE_STEP per frame; once fully on, pattern changes happen only on
// frame ticks, from a pending key press or (with TFT_PAT_AUTO_EN defined)
// automatically every FRAMES_PER_PAT frames.
// Build option: `define TFT_PAT_AUTO_EN enables the automatic advance.
module tft_pattern_ctrl
  import tft_pkg::*;
#(
  parameter int PAT_NUM        = 4,
  parameter int FRAMES_PER_PAT = 120,
  parameter int START_FRAMES   = 2,
  parameter int FADE_STEP      = 4
) (
  input  logic       clk_9m,
  input  logic       sys_rst_n,
  input  logic       vsync,
  input  logic       key_next,
  output logic [2:0] pat_sel,
  output logic       tft_bl,
  output logic       run
);

  localparam logic [2:0] PAT_LAST   = 3'(PAT_NUM - 1);
  localparam logic [3:0] START_LAST = 4'(START_FRAMES - 1);
  localparam logic [7:0] STEP8      = 8'(FADE_STEP);

  // Elaboration-time parameter legality checks.
  if (PAT_NUM < 2 || PAT_NUM > 8) begin : g_bad_pat_num
    $error("PAT_NUM out of range 2..8");
  end
  if (FRAMES_PER_PAT < 1 || FRAMES_PER_PAT > 4095) begin : g_bad_frames_per_pat
    $error("FRAMES_PER_PAT out of range 1..4095");
  end
  if (START_FRAMES < 1 || START_FRAMES > 15) begin : g_bad_start_frames
    $error("START_FRAMES out of range 1..15");
  end
  if (FADE_STEP < 1 || FADE_STEP > 255) begin : g_bad_fade_step
    $error("FADE_STEP out of range 1..255");
  end

  state_t     state, state_nx;
  logic [7:0] duty, duty_nx;
  logic [3:0] start_cnt, start_cnt_nx;
  logic [2:0] pat_nx;
  logic       pend, pend_nx;
  logic       run_nx;
  logic       advance;
  logic       vsync_q, vsync_d;
  logic       frame_tick;
`ifdef TFT_PAT_AUTO_EN
  localparam logic [11:0] FPP_LAST = 12'(FRAMES_PER_PAT - 1);
  logic [11:0] frame_cnt, frame_cnt_nx;
`endif

  // vsync_q is the sampled vsync; the tick is high for the one cycle after
  // the first edge that sees vsync high.
  assign frame_tick = vsync_q & ~vsync_d;

  // Next-state and datapath decisions for the start/fade/run sequence.
  always_comb begin
    state_nx     = state;
    duty_nx      = duty;
    start_cnt_nx = start_cnt;
    pat_nx       = pat_sel;
    pend_nx      = pend;
    advance      = 1'b0;
`ifdef TFT_PAT_AUTO_EN
    frame_cnt_nx = frame_cnt;
`endif
    case (state)
      S_OFF: begin
        duty_nx = 8'd0;
        if (frame_tick) begin
          if (start_cnt == START_LAST) begin
            state_nx     = S_FADE;
            start_cnt_nx = 4'd0;
          end else begin
            start_cnt_nx = start_cnt + 4'd1;
          end
        end else begin
          start_cnt_nx = start_cnt;
        end
      end
      S_FADE: begin
        if (frame_tick) begin
          duty_nx = sat_add(duty, STEP8);
          if (duty_nx == PWM_MAX) begin
            state_nx = S_RUN;
          end else begin
            state_nx = S_FADE;
          end
        end else begin
          duty_nx = duty;
        end
      end
      S_RUN: begin
        duty_nx = PWM_MAX;
        if (frame_tick) begin
          advance = pend;
`ifdef TFT_PAT_AUTO_EN
          if (frame_cnt == FPP_LAST) begin
            advance = 1'b1;
          end else begin
            advance = pend;
          end
          if (advance) begin
            frame_cnt_nx = 12'd0;
          end else begin
            frame_cnt_nx = frame_cnt + 12'd1;
          end
`endif
        end else begin
          advance = 1'b0;
        end
        // A key on the tick cycle arms the following frame, not this one.
        if (key_next) begin
          pend_nx = 1'b1;
        end else if (frame_tick) begin
          pend_nx = 1'b0;
        end else begin
          pend_nx = pend;
        end
        if (advance) begin
          pat_nx = next_pat(pat_sel, PAT_LAST);
        end else begin
          pat_nx = pat_sel;
        end
      end
      default: begin
        state_nx = S_OFF;
        duty_nx  = 8'd0;
      end
    endcase
    run_nx = (state_nx == S_RUN);
  end

  // State and sequencer registers.
  always_ff @(posedge clk_9m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_q   <= 1'b0;
      vsync_d   <= 1'b0;
      state     <= S_OFF;
      duty      <= 8'd0;
      start_cnt <= 4'd0;
      pat_sel   <= 3'd0;
      pend      <= 1'b0;
      run       <= 1'b0;
`ifdef TFT_PAT_AUTO_EN
      frame_cnt <= 12'd0;
`endif
    end else begin
      vsync_q   <= vsync;
      vsync_d   <= vsync_q;
      state     <= state_nx;
      duty      <= duty_nx;
      start_cnt <= start_cnt_nx;
      pat_sel   <= pat_nx;
      pend      <= pend_nx;
      run       <= run_nx;
`ifdef TFT_PAT_AUTO_EN
      frame_cnt <= frame_cnt_nx;
`endif
    end
  end

  bl_pwm u_bl_pwm (
    .clk    (clk_9m),
    .rst_n  (sys_rst_n),
    .duty   (duty),
    .tft_bl (tft_bl)
  );

endmodule

// File: tb/tb_tft_pattern_ctrl.sv
// Self-checking bench for tft_pattern_ctrl: a frame-level reference model
// predicts pat_sel, run and tft_bl every cycle; directed literal checks pin
// key milestones. Works with or without TFT_PAT_AUTO_EN.
module tb_tft_pattern_ctrl;

  localparam int PAT_NUM   = 4;
  localparam int FPP       = 3;
  localparam int START     = 2;
  localparam int STEP      = 4;
  localparam int FRAME_LEN = 40;

  logic       clk_9m = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       key_next = 1'b0;
  logic [2:0] pat_sel;
  logic       tft_bl;
  logic       run;

  int n_vec = 0;
  int n_err = 0;

  tft_pattern_ctrl #(
    .PAT_NUM(PAT_NUM), .FRAMES_PER_PAT(FPP), .START_FRAMES(START), .FADE_STEP(STEP)
  ) dut (
    .clk_9m(clk_9m), .sys_rst_n(sys_rst_n), .vsync(vsync), .key_next(key_next),
    .pat_sel(pat_sel), .tft_bl(tft_bl), .run(run)
  );

  always #5 clk_9m = ~clk_9m;

  // ---------------- reference model ----------------
  typedef struct {
    int   ticks;  // frame ticks since reset
    int   edges;  // clock edges since reset (= PWM counter value mod 256)
    logic v1;     // vsync seen at the previous edge
    logic v2;     // vsync seen two edges ago
    int   pat;
    logic pend;
    int   fc;     // run frames since last advance
    logic bl;
  } model_t;

  model_t m;

  // Backlight duty after t frame ticks: off for START ticks, then linear ramp.
  function automatic int duty_of(int t);
    int d;
    if (t <= START) d = 0;
    else d = STEP * (t - START);
    if (d > 255) d = 255;
    return d;
  endfunction

  function automatic bit running(int t);
    return duty_of(t) == 255;
  endfunction

  function automatic model_t step(model_t c, logic vs, logic key);
    model_t n;
    bit tick, adv;
    int d;
    n = c;
    tick = c.v1 && !c.v2;
    n.v2 = c.v1;
    n.v1 = vs;
    n.edges = c.edges + 1;
    d = duty_of(c.ticks);
    n.bl = (d == 255) || ((c.edges % 256) < d);
    if (running(c.ticks)) begin
      adv = 0;
      if (tick) begin
        adv = c.pend;
`ifdef TFT_PAT_AUTO_EN
        if (c.fc == FPP - 1) adv = 1;
`endif
        n.fc = adv ? 0 : c.fc + 1;
      end
      if (adv) n.pat = (c.pat + 1) % PAT_NUM;
      if (key) n.pend = 1'b1;
      else if (tick) n.pend = 1'b0;
    end
    if (tick) n.ticks = c.ticks + 1;
    return n;
  endfunction

  // Model advances on the same edges as the DUT and resets asynchronously.
  always @(posedge clk_9m or negedge sys_rst_n) begin
    if (!sys_rst_n) m <= '{default: 0};
    else m <= step(m, vsync, key_next);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk_9m) begin
    chk("pat_sel", 32'(pat_sel), 32'(m.pat));
    chk("run", 32'(run), 32'(running(m.ticks)));
    chk("tft_bl", 32'(tft_bl), 32'(m.bl));
  end

  // One frame: vsync high for 3 cycles, key pulses at given positions (-1 none).
  task automatic frame(input int k0, input int k1, input int k2);
    for (int i = 0; i < FRAME_LEN; i++) begin
      vsync = (i < 3);
      key_next = (i == k0) || (i == k1) || (i == k2);
      @(posedge clk_9m);
      #1;
    end
    vsync = 1'b0;
    key_next = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(-1, -1, -1);
  endtask

  task automatic start_seq();
    frames(START);
    chk("start_run", 32'(run), 32'd0);
    chk("start_bl", 32'(tft_bl), 32'd0);
    chk("start_pat", 32'(pat_sel), 32'd0);
    frame(10, -1, -1);               // key during fade is ignored
    chk("fade_key_pat", 32'(pat_sel), 32'd0);
    frames(62);                      // 65 ticks: duty 252
    chk("fade_last_run", 32'(run), 32'd0);
    frames(1);                       // 66th tick: duty 255
    chk("run_rise", 32'(run), 32'd1);
    chk("bl_full", 32'(tft_bl), 32'd1);
    chk("run_pat", 32'(pat_sel), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_9m);
    #1;
    chk("rst_pat", 32'(pat_sel), 32'd0);
    chk("rst_bl", 32'(tft_bl), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    sys_rst_n = 1'b1;

    start_seq();

    frames(3);
`ifdef TFT_PAT_AUTO_EN
    chk("auto_first", 32'(pat_sel), 32'd1);
`else
    chk("auto_first", 32'(pat_sel), 32'd0);
`endif
    frames(10);                      // 13 run frames: wrapped back to 0
    chk("auto_wrap", 32'(pat_sel), 32'd0);

    frame(10, -1, -1);               // key mid-frame: no change yet
    chk("key_hold", 32'(pat_sel), 32'd0);
    frames(1);                       // applied on next tick
    chk("key_adv", 32'(pat_sel), 32'd1);

    frame(5, 10, 15);                // three keys in one frame
    frames(1);
    chk("three_keys", 32'(pat_sel), 32'd2);

    frame(1, -1, -1);                // key coincides with the tick
    chk("key_on_tick", 32'(pat_sel), 32'd2);
    frames(1);
    chk("key_on_tick_next", 32'(pat_sel), 32'd3);

    frame(10, -1, -1);
    frames(1);
    chk("key_wrap", 32'(pat_sel), 32'd0);
    for (int i = 0; i < 2; i++) begin
      frame(10, -1, -1);
      frames(1);
    end
    chk("pre_reset_pat", 32'(pat_sel), 32'd2);

    // Asynchronous reset in the middle of a clock cycle.
    @(posedge clk_9m);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_pat", 32'(pat_sel), 32'd0);
    chk("arst_bl", 32'(tft_bl), 32'd0);
    chk("arst_run", 32'(run), 32'd0);
    repeat (2) @(posedge clk_9m);
    #1;
    sys_rst_n = 1'b1;

    start_seq();
    frames(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
